// File: rtl/round_pkg.sv
// Shared types and width helpers for the round/saturate pipeline.
// Imported by round_sat_lane and round_sat_pipe.
package round_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC,
    RND_HALF_UP,
    RND_HALF_EVEN,
    RND_RSVD
  } round_mode_e;

  function automatic int sh_bits(
    input int in_frac,
    input int out_frac
  );
    return in_frac - out_frac;
  endfunction

  // One spare bit above the shifted input so the increment never wraps.
  function automatic int rnd_width(
    input int in_int,
    input int in_frac,
    input int out_frac
  );
    return in_int + in_frac - sh_bits(in_frac, out_frac) + 1;
  endfunction

endpackage

// File: rtl/round_sat_lane.sv
// Combinational per-lane datapath: a rounding half and a saturating
// half, kept separate so a pipeline register can sit between them.
module round_sat_lane
  import round_pkg::*;
#(
  parameter int IN_INT_BITS   = 14,
  parameter int IN_FRAC_BITS  = 18,
  parameter int OUT_INT_BITS  = 7,
  parameter int OUT_FRAC_BITS = 9,
  localparam int IW = IN_INT_BITS + IN_FRAC_BITS,
  localparam int OW = OUT_INT_BITS + OUT_FRAC_BITS,
  localparam int SH = sh_bits(IN_FRAC_BITS, OUT_FRAC_BITS),
  localparam int RW = rnd_width(IN_INT_BITS, IN_FRAC_BITS,
                                OUT_FRAC_BITS)
) (
  input  logic [IW-1:0] rnd_in,
  input  round_mode_e   rnd_mode,
  output logic [RW-1:0] rnd_out,
  input  logic [RW-1:0] sat_in,
  output logic [OW-1:0] sat_out,
  output logic          sat_flag
);

  localparam logic signed [RW-1:0] MAX_V = RW'({(OW-1){1'b1}});
  localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

  logic signed [RW-1:0] q;

  assign q = RW'($signed(rnd_in[IW-1:SH]));

  if (SH == 0) begin : g_pass
    logic unused_mode;
    assign unused_mode = ^rnd_mode;
    assign rnd_out = q;
  end else begin : g_round
    logic half;
    logic rest;
    logic inc;

    assign half = rnd_in[SH-1];

    if (SH == 1) begin : g_no_rest
      assign rest = 1'b0;
    end else begin : g_rest
      assign rest = |rnd_in[SH-2:0];
    end

    always_comb begin
      inc = 1'b0;
      unique case (rnd_mode)
        RND_TRUNC:     inc = 1'b0;
        RND_HALF_EVEN: inc = half & (rest | q[0]);
        default:       inc = half;
      endcase
    end

    assign rnd_out = q + {{(RW-1){1'b0}}, inc};
  end

  logic hi;
  logic lo;

  assign hi = $signed(sat_in) > MAX_V;
  assign lo = $signed(sat_in) < MIN_V;
  assign sat_flag = hi | lo;

  always_comb begin
    sat_out = sat_in[OW-1:0];
    unique case (1'b1)
      hi:      sat_out = {1'b0, {(OW-1){1'b1}}};
      lo:      sat_out = {1'b1, {(OW-1){1'b0}}};
      default: sat_out = sat_in[OW-1:0];
    endcase
  end

endmodule

// File: rtl/round_sat_pipe.sv
// Multi-lane two-stage rounder/saturator with valid/ready streams.
// Define ROUND_SAT_CNT_EN to build the saturation event counter.
module round_sat_pipe
  import round_pkg::*;
#(
  parameter int IN_INT_BITS   = 14,
  parameter int IN_FRAC_BITS  = 18,
  parameter int OUT_INT_BITS  = 7,
  parameter int OUT_FRAC_BITS = 9,
  parameter int LANES         = 4,
  localparam int IW = IN_INT_BITS + IN_FRAC_BITS,
  localparam int OW = OUT_INT_BITS + OUT_FRAC_BITS,
  localparam int RW = rnd_width(IN_INT_BITS, IN_FRAC_BITS,
                                OUT_FRAC_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*IW-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*OW-1:0] out_data,
  output logic [LANES-1:0]    out_sat,
  output logic [LANES-1:0]    sat_sticky,
  input  logic                sat_clr,
  output logic [31:0]         sat_cnt
);

  if (IN_FRAC_BITS < OUT_FRAC_BITS ||
      IN_INT_BITS < OUT_INT_BITS) begin : g_bad_cfg
    $error("round_sat_pipe: output format wider than input");
  end

  logic                     s1_valid;
  logic [LANES-1:0][RW-1:0] s1_rnd;
  logic [LANES-1:0][RW-1:0] rnd_c;
  logic [LANES*OW-1:0]      sat_c;
  logic [LANES-1:0]         sat_f;
  logic                     s2_load;
  logic                     s1_load;
  logic                     fire;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign fire     = out_valid && out_ready;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    round_sat_lane #(
      .IN_INT_BITS  (IN_INT_BITS),
      .IN_FRAC_BITS (IN_FRAC_BITS),
      .OUT_INT_BITS (OUT_INT_BITS),
      .OUT_FRAC_BITS(OUT_FRAC_BITS)
    ) u_lane (
      .rnd_in  (in_data[k*IW +: IW]),
      .rnd_mode(round_mode_e'(mode_i)),
      .rnd_out (rnd_c[k]),
      .sat_in  (s1_rnd[k]),
      .sat_out (sat_c[k*OW +: OW]),
      .sat_flag(sat_f[k])
    );
  end

  // The mode only matters before S1, so it rides along implicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rnd   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_rnd   <= rnd_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      out_data  <= sat_c;
      out_sat   <= s1_valid ? sat_f : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_sticky <= '0;
    end else begin
      sat_sticky <= (sat_clr ? '0 : sat_sticky) |
                    (fire ? out_sat : '0);
    end
  end

`ifdef ROUND_SAT_CNT_EN
  logic [31:0] cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (fire && |out_sat) begin
      if (sat_clr) begin
        cnt_r <= 32'd1;
      end else if (cnt_r != 32'hFFFF_FFFF) begin
        cnt_r <= cnt_r + 32'd1;
      end
    end else if (sat_clr) begin
      cnt_r <= '0;
    end
  end

  assign sat_cnt = cnt_r;
`else
  assign sat_cnt = '0;
`endif

endmodule
